// File: rtl/expstate_irq_mmio.sv
// Watches EXPSTATE for bit transitions, latches them into PENDING and raises a masked level IRQ.
// Register port: single outstanding request, response one cycle after acceptance, held until resp_ready.
module expstate_irq_mmio #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             BReset,
   input  logic [WIDTH-1:0] EXPSTATE,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [3:0]       req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic             mmio_BInterruptXX
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RESP = 1'b1
   } state_t;

   localparam logic [1:0] A_STATUS  = 2'd0;
   localparam logic [1:0] A_PENDING = 2'd1;
   localparam logic [1:0] A_MASK    = 2'd2;
   localparam logic [1:0] A_CTRL    = 2'd3;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] exp_q;
   logic             primed_q;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic             irq_q, irq_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;

   logic             accept;
   logic             wr_acc;
   logic [1:0]       word;
   logic [WIDTH-1:0] ev;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rd_mux;
   logic             unused_addr_bits;

   assign word             = req_addr[3:2];
   assign unused_addr_bits = ^req_addr[1:0];

   // Register-port FSM
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign accept = req_valid & req_ready;
   assign wr_acc = accept & req_write;

   // Reads see pre-edge register contents.
   always_comb begin
      rd_mux = '0;
      case (word)
         A_STATUS:  rd_mux = exp_q;
         A_PENDING: rd_mux = pend_q;
         A_MASK:    rd_mux = mask_q;
         A_CTRL:    rd_mux = WIDTH'(ctrl_q);
         default:   rd_mux = '0;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (accept) begin
         rdata_d = req_write ? '0 : rd_mux;
         err_d   = req_write && (word == A_STATUS);
      end
   end

   always_comb begin
      ev = '0;
      if (primed_q) ev = ctrl_q[1] ? (EXPSTATE & ~exp_q) : (EXPSTATE ^ exp_q);
   end

   // Event OR'd in after the clear so a same-cycle event wins.
   always_comb begin
      clr    = (wr_acc && word == A_PENDING) ? req_wdata : '0;
      pend_d = (pend_q & ~clr) | ev;
      mask_d = (wr_acc && word == A_MASK) ? req_wdata : mask_q;
      ctrl_d = (wr_acc && word == A_CTRL) ? 2'(req_wdata) : ctrl_q;
      irq_d  = ctrl_q[0] & (|(pend_q & mask_q));
   end

   always_ff @(posedge CLK) begin
      if (BReset) begin
         state_q  <= S_IDLE;
         exp_q    <= '0;
         primed_q <= 1'b0;
         pend_q   <= '0;
         mask_q   <= '0;
         ctrl_q   <= '0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= EXPSTATE;
         primed_q <= 1'b1;
         pend_q   <= pend_d;
         mask_q   <= mask_d;
         ctrl_q   <= ctrl_d;
         irq_q    <= irq_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign resp_rdata        = rdata_q;
   assign resp_err          = err_q;
   assign mmio_BInterruptXX = irq_q;

endmodule

// File: tb/tb_expstate_irq_mmio.sv
// Directed bench for expstate_irq_mmio: register responses are checked through a scoreboard queue.
module tb_expstate_irq_mmio;

   logic        CLK;
   logic        BReset;
   logic [31:0] EXPSTATE;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [3:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        irq;

   int total = 0;
   int bad   = 0;
   logic [32:0] sb_q[$];

   expstate_irq_mmio #(.WIDTH(32)) dut (
      .CLK(CLK), .BReset(BReset), .EXPSTATE(EXPSTATE),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mmio_BInterruptXX(irq)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL timeout: bench did not reach summary");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   // Issue one request at the current negedge, hold resp_ready low for `hold` cycles.
   task automatic access(input string tag, input logic wr, input logic [3:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int hold);
      logic [32:0] exp_e;
      logic [31:0] snap;
      sb_q.push_back({exp_err, exp_rd});
      chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_addr   = addr;
      req_wdata  = wd;
      resp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      chk({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
      snap = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         chk({tag, "_bp_req_ready"}, {31'b0, req_ready}, 32'd0);
         tick();
         chk({tag, "_bp_valid"}, {31'b0, resp_valid}, 32'd1);
         chk({tag, "_bp_stable"}, resp_rdata, snap);
      end
      resp_ready = 1'b1;
      total++;
      assert (sb_q.size() != 0) else begin
         bad++;
         $error("FAIL %s_sb: observed=empty expected=entry", tag);
      end
      if (sb_q.size() != 0) begin
         exp_e = sb_q.pop_front();
         chk({tag, "_rdata"}, resp_rdata, exp_e[31:0]);
         chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_e[32]});
      end
      tick();
      resp_ready = 1'b0;
      chk({tag, "_done"}, {31'b0, resp_valid}, 32'd0);
   endtask

   initial begin
      BReset     = 1'b1;
      EXPSTATE   = 32'hFFFF_FFFF;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = 4'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;
      repeat (3) tick();
      BReset = 1'b0;

      // Reset values
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      tick();
      access("rst_pend", 1'b0, 4'h4, 32'h0, 32'h0, 1'b0, 0);
      access("rst_status", 1'b0, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 0);

      // Falling every bit latches all pending bits; IRQ stays off while EN=0
      EXPSTATE = 32'h0;
      tick(); tick();
      access("all_pend", 1'b0, 4'h4, 32'h0, 32'hFFFF_FFFF, 1'b0, 0);
      chk("all_pend_irq", {31'b0, irq}, 32'd0);
      access("clr_all", 1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
      access("clr_all_rd", 1'b0, 4'h4, 32'h0, 32'h0, 1'b0, 0);

      // Any-change event
      access("wr_mask1", 1'b1, 4'h8, 32'h1, 32'h0, 1'b0, 0);
      access("wr_ctrl1", 1'b1, 4'hC, 32'h1, 32'h0, 1'b0, 0);
      access("rd_ctrl1", 1'b0, 4'hC, 32'h0, 32'h1, 1'b0, 0);
      chk("pre_ev_irq", {31'b0, irq}, 32'd0);
      EXPSTATE = 32'h1;
      tick();
      chk("ev_irq_n1", {31'b0, irq}, 32'd0);
      tick();
      chk("ev_irq_n2", {31'b0, irq}, 32'd1);
      access("ev_pend", 1'b0, 4'h4, 32'h0, 32'h1, 1'b0, 0);

      // W1C colliding with a bit0 toggle: event wins
      EXPSTATE = 32'h0;
      access("coll_w1c", 1'b1, 4'h4, 32'h1, 32'h0, 1'b0, 0);
      chk("coll_irq", {31'b0, irq}, 32'd1);
      access("coll_pend", 1'b0, 4'h4, 32'h0, 32'h1, 1'b0, 0);
      access("quiet_w1c", 1'b1, 4'h4, 32'h1, 32'h0, 1'b0, 0);
      chk("quiet_irq", {31'b0, irq}, 32'd0);

      // RISE mode and masking
      access("wr_ctrl3", 1'b1, 4'hC, 32'h3, 32'h0, 1'b0, 0);
      EXPSTATE = 32'h2;
      tick(); tick();
      access("rise_b1_mask1", 1'b0, 4'h4, 32'h0, 32'h2, 1'b0, 0);
      chk("rise_b1_mask1_irq", {31'b0, irq}, 32'd0);
      access("clr_b1", 1'b1, 4'h4, 32'h2, 32'h0, 1'b0, 0);
      access("wr_mask2", 1'b1, 4'h8, 32'h2, 32'h0, 1'b0, 0);
      EXPSTATE = 32'h0;
      tick(); tick();
      access("fall_pend", 1'b0, 4'h4, 32'h0, 32'h0, 1'b0, 0);
      chk("fall_irq", {31'b0, irq}, 32'd0);
      EXPSTATE = 32'h2;
      tick();
      chk("rise_irq_n1", {31'b0, irq}, 32'd0);
      tick();
      chk("rise_irq_n2", {31'b0, irq}, 32'd1);
      EXPSTATE = 32'h12;
      tick(); tick();
      access("rise_b4_pend", 1'b0, 4'h4, 32'h0, 32'h12, 1'b0, 0);
      access("clr_b1_again", 1'b1, 4'h4, 32'h2, 32'h0, 1'b0, 0);
      chk("b4_unmasked_irq", {31'b0, irq}, 32'd0);
      access("b4_left", 1'b0, 4'h4, 32'h0, 32'h10, 1'b0, 0);

      // Backpressure and error
      access("bp_mask", 1'b0, 4'h8, 32'h0, 32'h2, 1'b0, 5);
      access("wr_status", 1'b1, 4'h0, 32'hDEAD_BEEF, 32'h0, 1'b1, 0);
      access("status_kept", 1'b0, 4'h0, 32'h0, 32'h12, 1'b0, 0);
      access("rd_ctrl3", 1'b0, 4'hC, 32'h0, 32'h3, 1'b0, 0);

      // Reset while a response is pending: dropped, never pushed to the scoreboard
      EXPSTATE  = 32'h0;
      tick();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 4'h4;
      tick();
      req_valid = 1'b0;
      chk("mid_resp_valid", {31'b0, resp_valid}, 32'd1);
      BReset = 1'b1;
      tick();
      chk("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
      chk("mid_rst_irq", {31'b0, irq}, 32'd0);
      chk("mid_rst_rdata", resp_rdata, 32'h0);
      resp_ready = 1'b1;
      EXPSTATE   = 32'h12;
      BReset     = 1'b0;
      tick();
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
      tick(); tick();
      chk("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
      resp_ready = 1'b0;
      access("post_pend", 1'b0, 4'h4, 32'h0, 32'h0, 1'b0, 0);
      access("post_mask", 1'b0, 4'h8, 32'h0, 32'h0, 1'b0, 0);
      access("post_ctrl", 1'b0, 4'hC, 32'h0, 32'h0, 1'b0, 0);
      access("post_status", 1'b0, 4'h0, 32'h0, 32'h12, 1'b0, 0);
      chk("post_irq", {31'b0, irq}, 32'd0);
      chk("sb_empty", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
